// File: rtl/cmd_script_player.sv
// Plays a loadable script of RemoteComm commands: sends each entry, waits for the
// response byte with a timeout, retries on silence and tallies pass/fail per entry.
module cmd_script_player #(
  parameter int unsigned        DEPTH         = 16,
  parameter int unsigned        CMD_W         = 16,
  parameter int unsigned        RESP_W        = 8,
  parameter int unsigned        TMO_W         = 24,
  parameter logic [TMO_W-1:0]   TIMEOUT       = TMO_W'(10_000_000),
  parameter int unsigned        MAX_RETRY     = 2,
  parameter logic [RESP_W-1:0]  COMPLETE_RESP = RESP_W'(8'hA5),
  localparam int unsigned       IW            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned       CW            = $clog2(DEPTH + 1),
  localparam int unsigned       RW            = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [IW-1:0]     load_addr,
  input  logic [CMD_W-1:0]  load_cmd,
  input  logic [CW-1:0]     load_len,
  input  logic              start,
  input  logic              stop_on_fail,
  output logic [CMD_W-1:0]  cmd,
  output logic              send_cmd,
  input  logic              cmd_sent,
  input  logic              resp_rdy,
  input  logic [RESP_W-1:0] resp,
  output logic              clr_rx_rdy,
  output logic              busy,
  output logic              done,
  output logic [IW-1:0]     cur_idx,
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_CHECK,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [CMD_W-1:0] script_mem [DEPTH];
  logic [CW-1:0]    len_q;
  logic             stop_q;
  logic             failed_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [RW-1:0]    retry_cnt;

  logic          waiting_c;
  logic          tmo_hit_c;
  logic          resp_take_c;
  logic          retry_ok_c;
  logic          last_c;
  logic          end_c;
  logic [CW-1:0] len_clamp_c;
  logic [IW-1:0] send_idx_c;

  // Condition decode shared by the FSM and the datapath
  always_comb begin
    waiting_c   = (state == S_WAIT_SENT) || (state == S_WAIT_RESP);
    tmo_hit_c   = waiting_c && (tmo_cnt == TIMEOUT - TMO_W'(1));
    resp_take_c = (state == S_WAIT_RESP) && resp_rdy;
    retry_ok_c  = 32'(retry_cnt) < MAX_RETRY;
    last_c      = CW'(cur_idx) == (len_q - CW'(1));
    end_c       = (failed_q && stop_q) || last_c;
    len_clamp_c = (load_len > CW'(DEPTH)) ? CW'(DEPTH) : load_len;
    send_idx_c  = cur_idx;
    if (state == S_IDLE) begin
      send_idx_c = '0;
    end else if (state == S_CHECK) begin
      send_idx_c = cur_idx + IW'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs; a response beats a same-cycle timeout
  always_comb begin
    state_nxt  = state;
    send_cmd   = 1'b0;
    clr_rx_rdy = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (len_clamp_c == '0) ? S_FIN : S_SEND;
        end
      end
      S_SEND: begin
        send_cmd  = 1'b1;
        state_nxt = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (tmo_hit_c) begin
          state_nxt = retry_ok_c ? S_SEND : S_CHECK;
        end else if (cmd_sent) begin
          state_nxt = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        clr_rx_rdy = resp_rdy;
        if (resp_rdy) begin
          state_nxt = S_CHECK;
        end else if (tmo_hit_c) begin
          state_nxt = retry_ok_c ? S_SEND : S_CHECK;
        end
      end
      S_CHECK: begin
        state_nxt = end_c ? S_FIN : S_SEND;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Script RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (load_en && (state == S_IDLE) && (32'(load_addr) < DEPTH)) begin
      script_mem[load_addr] <= load_cmd;
    end
  end

  // Playback datapath: command latch, timeout/retry tracking and tallies
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd       <= '0;
      cur_idx   <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      len_q     <= '0;
      stop_q    <= 1'b0;
      failed_q  <= 1'b0;
      tmo_cnt   <= '0;
      retry_cnt <= '0;
    end else begin
      // cmd is loaded on entry to SEND so it is already valid while send_cmd is high
      if (state_nxt == S_SEND) begin
        cmd <= script_mem[send_idx_c];
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= len_clamp_c;
            stop_q    <= stop_on_fail;
            cur_idx   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            retry_cnt <= '0;
            failed_q  <= 1'b0;
          end
        end
        S_SEND: begin
          tmo_cnt <= '0;
        end
        S_WAIT_SENT, S_WAIT_RESP: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (resp_take_c) begin
            if (resp == COMPLETE_RESP) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + CW'(1);
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CW'(1);
              failed_q <= 1'b1;
            end
          end else if (tmo_hit_c) begin
            if (retry_ok_c) begin
              retry_cnt <= retry_cnt + RW'(1);
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + CW'(1);
              failed_q <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          retry_cnt <= '0;
          failed_q  <= 1'b0;
          if (!end_c) begin
            cur_idx <= send_idx_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
